report_framer: RTL and testbench

- UART transmit-side framer for the temperature sensor: packs one measurement report into a fixed multi-byte frame and sends it byte by byte to the UART transmitter via tx_start/tx_data/tx_busy.
- Counterpart to the command-receive path (rx_data/rx_ready controller).
- Sits between the averaging/hysteresis logic and the UART; one frame per accepted send_req.

---
 rtl/report_framer.sv | 179 +++++++++++++++++
 tb/tb_report_framer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/report_framer.sv
// UART transmit framer: snapshots one sensor report and sends it as a fixed byte frame ending in an XOR checksum.
// Define REPORT_FRAMER_SEQ_EN to insert an 8-bit frame sequence number after the header.
module report_framer #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       send_req,
  input  logic [7:0] avg,
  input  logic [7:0] temp_high,
  input  logic [7:0] temp_low,
  input  logic       temp_warn,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       frame_err
);

  // state     | meaning
  // IDLE      | no frame in progress, accepts send_req
  // LOAD      | present byte[idx] on tx_data, wait for the UART to be free
  // START     | one-cycle tx_start pulse, clear busy timer
  // WAIT_BUSY | wait for the UART to acknowledge by raising tx_busy
  // WAIT_IDLE | wait for the byte to finish, then advance idx
  // DONE      | frame_done pulse
  // ABORT     | frame_err pulse, UART never acknowledged
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_IDLE,
    DONE,
    ABORT
  } state_t;

`ifdef REPORT_FRAMER_SEQ_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  // The START cycle counts as the first cycle of waiting, so ABORT is entered
  // exactly BUSY_TIMEOUT cycles after the tx_start pulse.
  localparam logic [15:0] WAIT_LAST = 16'(BUSY_TIMEOUT - 2);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  idx;
  logic [7:0]  snap_avg;
  logic [7:0]  snap_high;
  logic [7:0]  snap_low;
  logic        snap_warn;
  logic [7:0]  chk_acc;
  logic [15:0] wait_cnt;
  logic [7:0]  cur_byte;
`ifdef REPORT_FRAMER_SEQ_EN
  logic [7:0]  seq_cnt;
`endif

  always_comb begin
    cur_byte = HEADER;
    case (idx)
`ifdef REPORT_FRAMER_SEQ_EN
      3'd1:    cur_byte = seq_cnt;
      3'd2:    cur_byte = snap_avg;
      3'd3:    cur_byte = snap_high;
      3'd4:    cur_byte = snap_low;
      3'd5:    cur_byte = {7'b0, snap_warn};
      3'd6:    cur_byte = chk_acc;
`else
      3'd1:    cur_byte = snap_avg;
      3'd2:    cur_byte = snap_high;
      3'd3:    cur_byte = snap_low;
      3'd4:    cur_byte = {7'b0, snap_warn};
      3'd5:    cur_byte = chk_acc;
`endif
      default: cur_byte = HEADER;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tx_start   = 1'b0;
    frame_busy = 1'b1;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE: begin
        frame_busy = 1'b0;
        if (send_req) state_nxt = LOAD;
      end
      LOAD: begin
        if (!tx_busy) state_nxt = START;
      end
      START: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) state_nxt = WAIT_IDLE;
        else if (wait_cnt == WAIT_LAST) state_nxt = ABORT;
      end
      WAIT_IDLE: begin
        if (!tx_busy) state_nxt = (idx == LAST_IDX) ? DONE : LOAD;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      ABORT: begin
        frame_err = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      idx       <= 3'd0;
      snap_avg  <= 8'd0;
      snap_high <= 8'd0;
      snap_low  <= 8'd0;
      snap_warn <= 1'b0;
      chk_acc   <= 8'd0;
      wait_cnt  <= 16'd0;
      tx_data   <= 8'd0;
`ifdef REPORT_FRAMER_SEQ_EN
      seq_cnt   <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (send_req) begin
            snap_avg  <= avg;
            snap_high <= temp_high;
            snap_low  <= temp_low;
            snap_warn <= temp_warn;
            chk_acc   <= 8'd0;
            idx       <= 3'd0;
          end
        end
        LOAD: begin
          tx_data <= cur_byte;
          // fold each byte in once, on the cycle LOAD is left
          if (!tx_busy) chk_acc <= chk_acc ^ cur_byte;
        end
        START: wait_cnt <= 16'd0;
        WAIT_BUSY: begin
          if (!tx_busy) wait_cnt <= wait_cnt + 16'd1;
        end
        WAIT_IDLE: begin
          if (!tx_busy && idx != LAST_IDX) idx <= idx + 3'd1;
        end
        DONE: begin
          idx <= 3'd0;
`ifdef REPORT_FRAMER_SEQ_EN
          seq_cnt <= seq_cnt + 8'd1;
`endif
        end
        ABORT: idx <= 3'd0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_report_framer.sv
// Directed self-checking bench for report_framer with a simple UART busy model.
// Honours REPORT_FRAMER_SEQ_EN when building expected frames.
module tb_report_framer;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       send_req = 1'b0;
  logic [7:0] avg = 8'd0;
  logic [7:0] temp_high = 8'd0;
  logic [7:0] temp_low = 8'd0;
  logic       temp_warn = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       frame_busy;
  logic       frame_done;
  logic       frame_err;

  report_framer dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .send_req   (send_req),
    .avg        (avg),
    .temp_high  (temp_high),
    .temp_low   (temp_low),
    .temp_warn  (temp_warn),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .frame_busy (frame_busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] cap_q[$];
  int start_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int req_cyc = 0;
  int start_cyc = 0;
  int err_cyc = 0;
  int excl_viol = 0;
  int busy_left = 0;
  logic force_busy = 1'b0;
  logic uart_en = 1'b1;
  logic [7:0] seq_exp = 8'd0;

  // UART model: busy for 20 cycles starting the cycle after tx_start
  assign tx_busy = force_busy | (busy_left > 0);

  always @(posedge clk_in) begin
    cyc = cyc + 1;
    if (send_req) req_cyc = cyc;
    if (tx_start) begin
      cap_q.push_back(tx_data);
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end
    if (frame_done) done_cnt = done_cnt + 1;
    if (frame_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if ((frame_done && frame_err) || ((frame_done || frame_err) && tx_start))
      excl_viol = excl_viol + 1;
    if (tx_start && uart_en) busy_left <= 20;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_req();
    @(negedge clk_in);
    send_req = 1'b1;
    @(negedge clk_in);
    send_req = 1'b0;
  endtask

  task automatic wait_frame_end(input string tag);
    int d0 = done_cnt;
    int e0 = err_cnt;
    int k = 0;
    while (done_cnt == d0 && err_cnt == e0 && k < 600) begin
      @(negedge clk_in);
      k++;
    end
    check_val({tag, "_end"}, 32'(k < 600), 32'd1);
  endtask

  task automatic wait_starts(input string tag, input int target);
    int k = 0;
    while (start_cnt < target && k < 200) begin
      @(negedge clk_in);
      k++;
    end
    check_val({tag, "_start"}, 32'(start_cnt >= target), 32'd1);
  endtask

  // chk is the hand-computed checksum of the 6-byte frame; the sequence byte folds into it
  task automatic check_frame(input string tag, input logic [7:0] a, input logic [7:0] h,
                             input logic [7:0] l, input logic w, input logic [7:0] chk);
    logic [7:0] exp_b[$];
    exp_b.push_back(8'hA5);
`ifdef REPORT_FRAMER_SEQ_EN
    exp_b.push_back(seq_exp);
    chk = chk ^ seq_exp;
    seq_exp = seq_exp + 8'd1;
`endif
    exp_b.push_back(a);
    exp_b.push_back(h);
    exp_b.push_back(l);
    exp_b.push_back({7'b0, w});
    exp_b.push_back(chk);
    check_val({tag, "_len"}, 32'(cap_q.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < cap_q.size(); i++)
      check_val($sformatf("%s_b%0d", tag, i), 32'(cap_q[i]), 32'(exp_b[i]));
    cap_q.delete();
  endtask

  initial begin
    int s0;
    int d0;
    int e0;

    // reset state
    repeat (3) @(negedge clk_in);
    check_val("rst_tx_start", 32'(tx_start), 32'd0);
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    check_val("rst_busy", 32'(frame_busy), 32'd0);
    check_val("rst_done", 32'(frame_done), 32'd0);
    check_val("rst_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // basic frame: A5 3C 40 30 01 E8; tx_start two edges after the sampling edge
    avg = 8'h3C; temp_high = 8'h40; temp_low = 8'h30; temp_warn = 1'b1;
    s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
    pulse_req();
    wait_starts("basic", s0 + 1);
    check_val("basic_lat", 32'(start_cyc - req_cyc), 32'd2);
    wait_frame_end("basic");
    @(negedge clk_in);
    check_frame("basic", 8'h3C, 8'h40, 8'h30, 1'b1, 8'hE8);
    check_val("basic_done", 32'(done_cnt - d0), 32'd1);
    check_val("basic_noerr", 32'(err_cnt - e0), 32'd0);
    check_val("basic_idle", 32'(frame_busy), 32'd0);

    // snapshot: live inputs change after the first byte
    repeat (5) @(negedge clk_in);
    s0 = start_cnt;
    pulse_req();
    wait_starts("snap", s0 + 1);
    avg = 8'h00; temp_high = 8'hFF; temp_warn = 1'b0;
    wait_frame_end("snap");
    check_frame("snap", 8'h3C, 8'h40, 8'h30, 1'b1, 8'hE8);

    // overlap: requests during a frame are ignored
    avg = 8'h3C; temp_high = 8'h40; temp_low = 8'h30; temp_warn = 1'b1;
    repeat (5) @(negedge clk_in);
    d0 = done_cnt;
    pulse_req();
    for (int i = 0; i < 5; i++) begin
      repeat (22) @(negedge clk_in);
      pulse_req();
    end
    wait_frame_end("ovl");
    repeat (30) @(negedge clk_in);
    check_frame("ovl", 8'h3C, 8'h40, 8'h30, 1'b1, 8'hE8);
    check_val("ovl_done", 32'(done_cnt - d0), 32'd1);
    check_val("ovl_idle", 32'(frame_busy), 32'd0);

    // timeout: UART never acknowledges
    uart_en = 1'b0;
    s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
    pulse_req();
    wait_frame_end("tmo");
    @(negedge clk_in);
    check_val("tmo_starts", 32'(start_cnt - s0), 32'd1);
    check_val("tmo_err", 32'(err_cnt - e0), 32'd1);
    check_val("tmo_nodone", 32'(done_cnt - d0), 32'd0);
    check_val("tmo_delay", 32'(err_cyc - start_cyc), 32'd16);
    check_val("tmo_idle", 32'(frame_busy), 32'd0);
    cap_q.delete();
    uart_en = 1'b1;

    // backpressure: UART busy before the request
    force_busy = 1'b1;
    repeat (50) @(negedge clk_in);
    avg = 8'hFF; temp_high = 8'h00; temp_low = 8'hFF; temp_warn = 1'b1;
    s0 = start_cnt;
    pulse_req();
    repeat (10) @(negedge clk_in);
    check_val("bp_hold", 32'(start_cnt - s0), 32'd0);
    check_val("bp_busy", 32'(frame_busy), 32'd1);
    check_val("bp_data", 32'(tx_data), 32'hA5);
    force_busy = 1'b0;
    wait_frame_end("bp");
    check_frame("bp", 8'hFF, 8'h00, 8'hFF, 1'b1, 8'hA4);

    // reset mid-frame during the third byte
    avg = 8'h3C; temp_high = 8'h40; temp_low = 8'h30; temp_warn = 1'b1;
    repeat (5) @(negedge clk_in);
    s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
    pulse_req();
    wait_starts("mrst", s0 + 3);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b0;
    @(negedge clk_in);
    check_val("mrst_tx_start", 32'(tx_start), 32'd0);
    check_val("mrst_busy", 32'(frame_busy), 32'd0);
    check_val("mrst_tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_in);
    check_val("mrst_nodone", 32'(done_cnt - d0), 32'd0);
    check_val("mrst_noerr", 32'(err_cnt - e0), 32'd0);
    cap_q.delete();
    seq_exp = 8'd0;
    avg = 8'h12; temp_high = 8'h80; temp_low = 8'h05; temp_warn = 1'b0;
    pulse_req();
    wait_frame_end("post");
    check_frame("post", 8'h12, 8'h80, 8'h05, 1'b0, 8'h32);

    check_val("excl", 32'(excl_viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
